seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector with a runtime-programmable pattern and length, selectable overlapping or non-overlapping matching, a qualifying valid strobe and a saturating match counter. It is the general-purpose successor to the fixed three-bit Moore detector and sits between a serial bit source and the control or monitor logic that consumes match events.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_if.sv | 37 +++
 rtl/seq_det_window.sv | 63 ++++++
 rtl/seq_detector_param.sv | 124 ++++++++++++
 tb/tb_seq_detector_param.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - state_t   : detector FSM states (IDLE, HUNT, HIT)
//   - len_legal : accepts a configured pattern length in 1..max_len
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// -----------------------------------------------------------------------------
// seq_det_if
// Bundles the configuration, serial-input and status signals of the detector.
//   master : drives cfg_*, clear, s_valid, s_in; observes the status outputs
//   slave  : the detector side (seq_detector_param)
// Inputs : cfg_load, cfg_pattern[PAT_W], cfg_len[LEN_W], cfg_overlap, clear,
//          s_valid, s_in
// Outputs: match, match_cnt[CNT_W], cnt_sat, cfg_err, armed
// -----------------------------------------------------------------------------
interface seq_det_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             clear;
    logic             s_valid;
    logic             s_in;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             cfg_err;
    logic             armed;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear, s_valid, s_in,
        input  match, match_cnt, cnt_sat, cfg_err, armed
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear, s_valid, s_in,
        output match, match_cnt, cnt_sat, cfg_err, armed
    );
endinterface

// File: rtl/seq_det_window.sv
// -----------------------------------------------------------------------------
// seq_det_window
// Serial shift window, fill counter and length-masked comparator.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   i_flush    : empties window and fill count (has priority over i_shift)
//   i_shift    : accept i_bit this cycle
//   i_bit      : serial data bit, newest bit lands in window bit 0
//   i_pattern  : latched pattern, bit [len-1] is the oldest expected bit
//   i_len      : latched pattern length
//   i_overlap  : 0 = fill count restarts after each match
//   o_hit_next : the bit being accepted this cycle completes a match
// -----------------------------------------------------------------------------
module seq_det_window #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_shift,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_overlap,
    output logic             o_hit_next
);
    logic [PAT_W-1:0] r_win;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_win_nxt;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_fill_inc;
    logic [LEN_W-1:0] w_fill_sat;
    logic             w_full;

    always_comb begin
        w_win_nxt  = {r_win[PAT_W-2:0], i_bit};
        // One extra bit so the increment cannot wrap before the compare.
        w_fill_inc = {1'b0, r_fill} + (LEN_W + 1)'(1);
        w_full     = (w_fill_inc >= {1'b0, i_len});
        w_fill_sat = w_full ? i_len : w_fill_inc[LEN_W-1:0];
        // Only the low len bits of window and pattern take part in the compare.
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
        o_hit_next = i_shift && w_full && (((w_win_nxt ^ i_pattern) & w_mask) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_win  <= w_win_nxt;
            // Non-overlap: the next match must be built from len fresh bits.
            r_fill <= (o_hit_next && !i_overlap) ? '0 : w_fill_sat;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable serial bit-pattern detector with overlap control,
// valid qualification and a saturating match counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_det_if.slave
//           in : cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear, s_valid, s_in
//           out: match (1-cycle pulse per match), match_cnt (saturating),
//                cnt_sat, cfg_err (1-cycle pulse on rejected load), armed
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input logic      clk,
    input logic      reset,
    seq_det_if.slave bus
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_cnt_sat;
    logic             r_cfg_err;

    logic             w_cfg_legal;
    logic             w_cfg_reject;
    logic             w_flush;
    logic             w_shift;
    logic             w_hit_next;

    assign w_cfg_legal  = bus.cfg_load && len_legal(32'(bus.cfg_len), PAT_W);
    assign w_cfg_reject = bus.cfg_load && !w_cfg_legal;
    // A legal load or a clear both restart the window and drop this cycle's bit;
    // a rejected load leaves the bit to be processed with the old configuration.
    assign w_flush      = bus.clear || w_cfg_legal;
    assign w_shift      = r_armed && bus.s_valid && !w_flush;

    seq_det_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (w_flush),
        .i_shift    (w_shift),
        .i_bit      (bus.s_in),
        .i_pattern  (r_pattern),
        .i_len      (r_len),
        .i_overlap  (r_overlap),
        .o_hit_next (w_hit_next)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            IDLE: begin
                if (w_cfg_legal) begin
                    w_state_nxt = HUNT;
                end
            end
            HUNT, HIT: begin
                if (w_flush) begin
                    w_state_nxt = HUNT;
                end else if (w_hit_next) begin
                    w_state_nxt = HIT;
                end else begin
                    w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Clear wins over a same-cycle match; w_hit_next is already masked by flush.
        if (bus.clear) begin
            w_cnt_nxt = '0;
        end else if (w_hit_next && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_cnt_sat <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cnt_sat <= (w_cnt_nxt == '1);
            r_cfg_err <= w_cfg_reject;
            if (w_cfg_legal) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_overlap <= bus.cfg_overlap;
                r_armed   <= 1'b1;
            end
        end
    end

    assign bus.match     = (r_state == HIT);
    assign bus.match_cnt = r_cnt;
    assign bus.cnt_sat   = r_cnt_sat;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.armed     = r_armed;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Two detectors (8-bit and 2-bit match counters) share one stimulus stream.
// Expected responses come from a bit-history reference model and are queued
// per cycle; a monitor pops and compares one entry after each clock edge.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;
    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_det_if #(.PAT_W(PAT_W), .CNT_W(8)) bus8 ();
    seq_det_if #(.PAT_W(PAT_W), .CNT_W(2)) bus2 ();

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));
    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    assign bus2.cfg_load    = bus8.cfg_load;
    assign bus2.cfg_pattern = bus8.cfg_pattern;
    assign bus2.cfg_len     = bus8.cfg_len;
    assign bus2.cfg_overlap = bus8.cfg_overlap;
    assign bus2.clear       = bus8.clear;
    assign bus2.s_valid     = bus8.s_valid;
    assign bus2.s_in        = bus8.s_in;

    typedef struct packed {
        logic       match;
        logic [7:0] cnt8;
        logic       sat8;
        logic [1:0] cnt2;
        logic       sat2;
        logic       err;
        logic       armed;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: configuration plus the bits seen since the last flush.
    bit       m_armed;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ov;
    bit       m_err;
    int       m_cnt;
    bit       hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tail_match();
        if (hist.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (hist[hist.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input logic rn, input logic ld, input logic [7:0] pat,
                              input logic [3:0] len, input logic ov, input logic clr,
                              input logic v, input logic b, output exp_t e);
        bit legal;
        bit m;
        m = 1'b0;
        if (!rn) begin
            m_armed = 1'b0; m_pat = '0; m_len = 0; m_ov = 1'b0;
            m_err = 1'b0; m_cnt = 0; hist.delete();
        end else begin
            legal = ld && (len >= 1) && (len <= PAT_W);
            m_err = ld && !legal;
            if (clr || legal) begin
                hist.delete();
                if (clr) m_cnt = 0;
                if (legal) begin
                    m_armed = 1'b1; m_pat = pat; m_len = int'(len); m_ov = ov;
                end
            end else if (m_armed && v) begin
                hist.push_back(b);
                if (hist.size() > 32) hist.delete(0);
                if (tail_match()) begin
                    m = 1'b1;
                    m_cnt++;
                    if (!m_ov) hist.delete();
                end
            end
        end
        e.match = m;
        e.cnt8  = (m_cnt >= 255) ? 8'hff : 8'(m_cnt);
        e.sat8  = (m_cnt >= 255);
        e.cnt2  = (m_cnt >= 3) ? 2'b11 : 2'(m_cnt);
        e.sat2  = (m_cnt >= 3);
        e.err   = m_err;
        e.armed = m_armed;
    endtask

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic step(input logic rn, input logic ld, input logic [7:0] pat,
                        input logic [3:0] len, input logic ov, input logic clr,
                        input logic v, input logic b);
        exp_t e;
        reset            = rn;
        bus8.cfg_load    = ld;
        bus8.cfg_pattern = pat;
        bus8.cfg_len     = len;
        bus8.cfg_overlap = ov;
        bus8.clear       = clr;
        bus8.s_valid     = v;
        bus8.s_in        = b;
        model_step(rn, ld, pat, len, ov, clr, v, b, e);
        q.push_back(e);
        if (!rn) begin
            #1;
            chk("async_rst_match", 32'(bus8.match), 32'd0);
            chk("async_rst_cnt",   32'(bus8.match_cnt), 32'd0);
            chk("async_rst_armed", 32'(bus8.armed), 32'd0);
            chk("async_rst_err",   32'(bus8.cfg_err), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        step(1'b1, 1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sbit(input logic v, input logic b);
        step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, v, b);
    endtask

    task automatic clr_load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        step(1'b1, 1'b1, pat, len, ov, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present their registered status.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("match8",  32'(bus8.match),     32'(mon_e.match));
            chk("match2",  32'(bus2.match),     32'(mon_e.match));
            chk("cnt8",    32'(bus8.match_cnt), 32'(mon_e.cnt8));
            chk("sat8",    32'(bus8.cnt_sat),   32'(mon_e.sat8));
            chk("cnt2",    32'(bus2.match_cnt), 32'(mon_e.cnt2));
            chk("sat2",    32'(bus2.cnt_sat),   32'(mon_e.sat2));
            chk("cfg_err", 32'(bus8.cfg_err),   32'(mon_e.err));
            chk("armed",   32'(bus8.armed),     32'(mon_e.armed));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rl;
        int         r;
        reset = 1'b1;
        bus8.cfg_load = 1'b0; bus8.cfg_pattern = '0; bus8.cfg_len = '0;
        bus8.cfg_overlap = 1'b0; bus8.clear = 1'b0; bus8.s_valid = 1'b0; bus8.s_in = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sbit(1'b1, 1'b1);

        // Pattern 100, non-overlap: matches after bits 3 and 6
        load(8'b100, 4'd3, 1'b0);
        foreach (hist[i]) begin end
        sbit(1'b1, 1'b1); sbit(1'b1, 1'b0); sbit(1'b1, 1'b0);
        sbit(1'b1, 1'b1); sbit(1'b1, 1'b0); sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b0);

        // Pattern 11 overlap, then non-overlap
        clr_load(8'b11, 4'd2, 1'b1);
        repeat (4) sbit(1'b1, 1'b1);
        sbit(1'b0, 1'b0);
        clr_load(8'b11, 4'd2, 1'b0);
        repeat (4) sbit(1'b1, 1'b1);
        sbit(1'b0, 1'b0);

        // 100 with valid gaps
        clr_load(8'b100, 4'd3, 1'b0);
        sbit(1'b1, 1'b1); sbit(1'b0, 1'b0); sbit(1'b0, 1'b1);
        sbit(1'b1, 1'b0); sbit(1'b0, 1'b1); sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b0); sbit(1'b0, 1'b0);

        // Illegal lengths rejected, detection continues with the old pattern
        sbit(1'b1, 1'b1);
        step(1'b1, 1'b1, 8'b11, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'b11, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        sbit(1'b1, 1'b1); sbit(1'b1, 1'b0); sbit(1'b1, 1'b0);

        // Reset mid-pattern, reload, one more bit: no match
        load(8'b100, 4'd3, 1'b0);
        sbit(1'b1, 1'b1); sbit(1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        sbit(1'b0, 1'b0);
        load(8'b100, 4'd3, 1'b0);
        sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b0);

        // Saturation on the 2-bit counter, then clear keeps armed
        clr_load(8'b1, 4'd1, 1'b1);
        repeat (5) sbit(1'b1, 1'b1);
        sbit(1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        sbit(1'b0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 299));
            if (r == 0) begin
                step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else if (r < 8) begin
                r = int'($urandom_range(0, 19));
                if (r == 0)      rl = 4'd0;
                else if (r == 1) rl = 4'(9 + $urandom_range(0, 6));
                else if (r < 5)  rl = 4'($urandom_range(5, 8));
                else             rl = 4'($urandom_range(1, 4));
                step(1'b1, 1'b1, 8'($urandom), rl, 1'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
            end else begin
                step(1'b1, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom),
                     ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
            end
        end

        sbit(1'b0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
